// File: rtl/pad_motion_controller.sv
// Player pad position controller: synchronised up/down requests, direction FSM and clamped
// movement. Define PAD_ACCEL_EN to compile in hold-to-accelerate velocity.
module pad_motion_controller #(
  parameter int unsigned Y_W          = 10,
  parameter int unsigned SCREEN_H     = 768,
  parameter int unsigned PAD_HEIGHT   = 145,
  parameter int unsigned Y_MIN        = 4,
  parameter int unsigned Y_MAX_BOTTOM = SCREEN_H - 4,
  parameter int unsigned Y_RESET      = (SCREEN_H - 72) / 2,
  parameter int unsigned V_MIN        = 3,
  parameter int unsigned V_MAX        = 6,
  parameter int unsigned ACCEL_TICKS  = 4,
  parameter logic [1:0]  PLAY_CODE    = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           timing_tick,
  input  logic           up_in,
  input  logic           down_in,
  input  logic [1:0]     state,
  output logic [Y_W-1:0] y_pad,
  output logic [3:0]     velocity,
  output logic           moving,
  output logic           at_top,
  output logic           at_bottom
);

  localparam logic [Y_W-1:0] YMin    = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] YTopMax = Y_W'(Y_MAX_BOTTOM - PAD_HEIGHT + 1);
  localparam logic [Y_W-1:0] YReset  = Y_W'(Y_RESET);
  localparam logic [3:0]     VMin    = 4'(V_MIN);

  if (V_MAX < V_MIN || V_MAX > 15 || ACCEL_TICKS == 0 ||
      Y_MAX_BOTTOM + 1 < PAD_HEIGHT + Y_MIN) begin : gen_bad_cfg
    $error("pad_motion_controller: inconsistent geometry or velocity parameters");
  end

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic           up_meta_q, up_s_q, down_meta_q, down_s_q;
  logic           in_play, req_up, req_down, req_move;
  logic [Y_W-1:0] y_q, y_d, y_step;
  logic [Y_W:0]   y_ext, v_ext;
  logic [3:0]     vel_cur;
  logic           moving_q, at_top_q, at_bottom_q;

  assign in_play  = (state == PLAY_CODE);
  assign req_up   = up_s_q & ~down_s_q;
  assign req_down = down_s_q & ~up_s_q;
  assign req_move = req_up | req_down;

  // Two-flop synchronisers; they keep running outside play.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_meta_q   <= 1'b0;
      up_s_q      <= 1'b0;
      down_meta_q <= 1'b0;
      down_s_q    <= 1'b0;
    end else begin
      up_meta_q   <= up_in;
      up_s_q      <= up_meta_q;
      down_meta_q <= down_in;
      down_s_q    <= down_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (!in_play) begin
      fsm_d = StIdle;
    end else if (timing_tick) begin
      if (req_up) begin
        fsm_d = StMoveUp;
      end else if (req_down) begin
        fsm_d = StMoveDown;
      end else begin
        fsm_d = StIdle;
      end
    end
  end

`ifdef PAD_ACCEL_EN
  localparam int unsigned     CntW    = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCEL_TICKS - 1);
  localparam logic [3:0]      VMax    = 4'(V_MAX);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_cur;
  logic [3:0]      vel_q, vel_d;
  logic            reversal, hit_limit;

  // A reversal restarts from V_MIN before this tick's move is taken.
  assign reversal  = (fsm_q == StMoveUp && req_down) || (fsm_q == StMoveDown && req_up);
  assign vel_cur   = reversal ? VMin : vel_q;
  assign cnt_cur   = reversal ? '0 : cnt_q;
  assign hit_limit = (req_up && y_step == YMin) || (req_down && y_step == YTopMax);
`else
  assign vel_cur = VMin;
`endif

  // Clamped candidate position; compares are one bit wider so nothing wraps.
  always_comb begin
    y_ext  = {1'b0, y_q};
    v_ext  = (Y_W + 1)'(vel_cur);
    y_step = y_q;
    if (req_up) begin
      y_step = (y_ext < {1'b0, YMin} + v_ext) ? YMin : y_q - Y_W'(vel_cur);
    end else if (req_down) begin
      y_step = (y_ext + v_ext > {1'b0, YTopMax}) ? YTopMax : y_q + Y_W'(vel_cur);
    end
  end

  always_comb begin
    y_d = y_q;
`ifdef PAD_ACCEL_EN
    vel_d = vel_q;
    cnt_d = cnt_q;
`endif
    if (!in_play) begin
      y_d = YReset;
`ifdef PAD_ACCEL_EN
      vel_d = VMin;
      cnt_d = '0;
`endif
    end else if (timing_tick) begin
      if (req_move) begin
        y_d = y_step;
      end
`ifdef PAD_ACCEL_EN
      if (!req_move || hit_limit) begin
        vel_d = VMin;
        cnt_d = '0;
      end else if (cnt_cur == CntLast) begin
        cnt_d = '0;
        vel_d = (vel_cur < VMax) ? vel_cur + 4'd1 : vel_cur;
      end else begin
        cnt_d = cnt_cur + CntW'(1);
        vel_d = vel_cur;
      end
`endif
    end
  end

  // Flags come from next-state values so they line up with y_pad in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= YReset;
      moving_q    <= 1'b0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
`ifdef PAD_ACCEL_EN
      vel_q       <= VMin;
      cnt_q       <= '0;
`endif
    end else begin
      y_q         <= y_d;
      moving_q    <= (fsm_d != StIdle);
      at_top_q    <= (y_d == YMin);
      at_bottom_q <= (y_d == YTopMax);
`ifdef PAD_ACCEL_EN
      vel_q       <= vel_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign y_pad     = y_q;
`ifdef PAD_ACCEL_EN
  assign velocity  = vel_q;
`else
  assign velocity  = VMin;
`endif
  assign moving    = moving_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bottom_q;

endmodule
